// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the program counter and sequences
// IDLE -> RUN -> DONE, with stall, absolute/relative branch and halt control.
module inst_fetch_ctrl #(
  parameter int unsigned A  = 10,  // instruction address width
  parameter int unsigned CW = 16   // cycle-counter width
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          BranchAbs,
  input  logic [A-1:0]  Target,
  input  logic          BranchRel,
  input  logic [7:0]    Offset,
  output logic [A-1:0]  InstAddress,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [A-1:0]  offset_ext;

  // Sign-extend the displacement to address width; the add then wraps mod 2**A.
  assign offset_ext = A'($signed(Offset));

  // State, PC and cycle counter registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, next-PC and counter update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        // Only Start/StartAddr matter outside RUN.
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Every RUN cycle counts, including the one that sees Halt.
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (Halt) begin
          state_d = StDone;
        end else if (!Stall) begin
          if (BranchAbs) begin
            pc_d = Target;
          end else if (BranchRel) begin
            pc_d = pc_q + offset_ext;
          end else begin
            pc_d = pc_q + A'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode directly from registered state.
  always_comb begin
    InstAddress = pc_q;
    CycleCount  = cnt_q;
    InstValid   = (state_q == StRun);
    Busy        = (state_q == StRun);
    Done        = (state_q == StDone);
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios followed by
// random control traffic, all checked against a behavioural model.
module tb_inst_fetch_ctrl;

  localparam int A  = 10;
  localparam int CW = 6;  // narrow counter so saturation is reachable
  localparam int AMOD = 1 << A;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Start, Halt, Stall, BranchAbs, BranchRel;
  logic [A-1:0]  StartAddr, Target;
  logic [7:0]    Offset;
  logic [A-1:0]  InstAddress;
  logic          InstValid, Busy, Done;
  logic [CW-1:0] CycleCount;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_st, m_pc, m_cnt;

  always #5 Clk = ~Clk;

  inst_fetch_ctrl #(.A(A), .CW(CW)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Halt       (Halt),
    .Stall      (Stall),
    .BranchAbs  (BranchAbs),
    .Target     (Target),
    .BranchRel  (BranchRel),
    .Offset     (Offset),
    .InstAddress(InstAddress),
    .InstValid  (InstValid),
    .Busy       (Busy),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string where);
    chk({where, ".addr"},  32'(InstAddress), 32'(m_pc));
    chk({where, ".valid"}, 32'(InstValid),   32'(m_st == M_RUN));
    chk({where, ".busy"},  32'(Busy),        32'(m_st == M_RUN));
    chk({where, ".done"},  32'(Done),        32'(m_st == M_DONE));
    chk({where, ".cnt"},   32'(CycleCount),  32'(m_cnt));
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_pc  = 0;
    m_cnt = 0;
  endtask

  // One rising edge of the behavioural model, using the inputs now applied.
  task automatic model_edge();
    int off;
    if (!Reset_n) begin
      model_reset();
    end else if (m_st == M_RUN) begin
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      off = (Offset >= 8'd128) ? int'(Offset) - 256 : int'(Offset);
      if (Halt)           m_st = M_DONE;
      else if (Stall)     m_pc = m_pc;
      else if (BranchAbs) m_pc = int'(Target);
      else if (BranchRel) m_pc = ((m_pc + off) % AMOD + AMOD) % AMOD;
      else                m_pc = (m_pc + 1) % AMOD;
    end else if (Start) begin
      m_pc  = int'(StartAddr);
      m_cnt = 0;
      m_st  = M_RUN;
    end
  endtask

  task automatic clr();
    Start     = 1'b0;
    StartAddr = '0;
    Halt      = 1'b0;
    Stall     = 1'b0;
    BranchAbs = 1'b0;
    Target    = '0;
    BranchRel = 1'b0;
    Offset    = '0;
  endtask

  // Advance one clock, update the model, sample 1 time unit after the edge.
  task automatic step(input string where);
    @(posedge Clk);
    model_edge();
    #1;
    chk_model(where);
  endtask

  task automatic chk_reset_vals(input string where);
    chk({where, ".addr"},  32'(InstAddress), 32'd0);
    chk({where, ".valid"}, 32'(InstValid),   32'd0);
    chk({where, ".busy"},  32'(Busy),        32'd0);
    chk({where, ".done"},  32'(Done),        32'd0);
    chk({where, ".cnt"},   32'(CycleCount),  32'd0);
  endtask

  initial begin
    clr();
    Reset_n = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("por");
    Reset_n = 1'b1;

    // Idle holds with controls asserted but no Start
    Stall = 1'b1; BranchAbs = 1'b1; Target = 10'd77; Halt = 1'b1;
    step("idle_ignore");
    clr();

    // Free-run from 5
    Start = 1'b1; StartAddr = 10'd5;
    step("start5");
    chk("start5.addr_c", 32'(InstAddress), 32'd5);
    clr();
    step("run6");
    chk("run6.addr_c", 32'(InstAddress), 32'd6);
    step("run7");
    // Start while running is ignored
    Start = 1'b1; StartAddr = 10'd500;
    step("run8_start_ign");
    chk("run8.addr_c", 32'(InstAddress), 32'd8);
    clr();
    step("run9");
    chk("run9.cnt_c", 32'(CycleCount), 32'd4);
    Halt = 1'b1;
    step("halt_a");
    chk("halt_a.cnt_c", 32'(CycleCount), 32'd5);
    clr();

    // Address wrap at top of memory
    Start = 1'b1; StartAddr = 10'd1022;
    step("wrap_start");
    clr();
    step("wrap1023");
    step("wrap0");
    chk("wrap0.addr_c", 32'(InstAddress), 32'd0);
    step("wrap1");
    chk("wrap1.addr_c", 32'(InstAddress), 32'd1);
    Halt = 1'b1;
    step("halt_b");
    clr();

    // Relative and absolute branches
    Start = 1'b1; StartAddr = 10'd10;
    step("br_start");
    clr();
    BranchRel = 1'b1; Offset = 8'hFD;
    step("br_rel_m3");
    chk("br_rel_m3.addr_c", 32'(InstAddress), 32'd7);
    BranchAbs = 1'b1; Target = 10'd100; Offset = 8'd5;
    step("br_abs_wins");
    chk("br_abs_wins.addr_c", 32'(InstAddress), 32'd100);
    clr();
    BranchRel = 1'b1; Offset = 8'h80;  // -128 wraps below zero
    BranchAbs = 1'b1; Target = 10'd3;
    step("br_to3");
    BranchAbs = 1'b0;
    step("br_rel_wrap_down");
    chk("br_rel_wrap_down.addr_c", 32'(InstAddress), 32'd899);
    clr();

    // Stall, then Halt beats Stall and BranchAbs
    BranchAbs = 1'b1; Target = 10'd20;
    step("to20");
    clr();
    Stall = 1'b1;
    step("stall_1");
    step("stall_2");
    chk("stall_2.addr_c", 32'(InstAddress), 32'd20);
    clr();
    step("after_stall");
    chk("after_stall.addr_c", 32'(InstAddress), 32'd21);
    Halt = 1'b1; Stall = 1'b1; BranchAbs = 1'b1; Target = 10'd300;
    step("halt_prio");
    chk("halt_prio.addr_c", 32'(InstAddress), 32'd21);
    chk("halt_prio.done_c", 32'(Done), 32'd1);
    chk("halt_prio.valid_c", 32'(InstValid), 32'd0);
    clr();

    // DONE ignores controls, then restarts on Start
    BranchAbs = 1'b1; Target = 10'd400; BranchRel = 1'b1; Offset = 8'd9;
    step("done_ignore");
    clr();
    Start = 1'b1; StartAddr = 10'd0;
    step("restart0");
    chk("restart0.cnt_c", 32'(CycleCount), 32'd0);
    clr();

    // Counter saturates instead of wrapping
    for (int i = 0; i < CMAX + 6; i++) step("sat_run");
    chk("sat.cnt_c", 32'(CycleCount), 32'(CMAX));

    // Asynchronous reset mid-RUN at PC=37
    BranchAbs = 1'b1; Target = 10'd37;
    step("to37");
    clr();
    #3;
    Reset_n = 1'b0;
    Start = 1'b1; StartAddr = 10'd44;
    model_reset();
    #1;
    chk_reset_vals("async_rst");
    step("rst_hold_1");
    step("rst_hold_2");
    #2;
    Start = 1'b0;
    Reset_n = 1'b1;
    step("post_rst_idle");
    Start = 1'b1; StartAddr = 10'd3;
    step("post_rst_start");
    chk("post_rst_start.addr_c", 32'(InstAddress), 32'd3);
    clr();

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      Start     = ($urandom_range(0, 3) == 0);
      StartAddr = A'($urandom);
      Halt      = ($urandom_range(0, 15) == 0);
      Stall     = ($urandom_range(0, 3) == 0);
      BranchAbs = ($urandom_range(0, 5) == 0);
      Target    = A'($urandom);
      BranchRel = ($urandom_range(0, 3) == 0);
      Offset    = 8'($urandom);
      step("rand");
    end
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
